// File: rtl/floo_rob_rsp_tagger_pkg.sv
// Shared types for the target-side RoB response tagger: meta entry layout and
// the modulo helper that turns a base slot plus a beat offset into a RoB index.
package floo_rob_rsp_tagger_pkg;

  localparam int unsigned RobSize  = 64;
  localparam int unsigned RobIdxW  = $clog2(RobSize);
  localparam int unsigned AxLenW   = 8;
  localparam int unsigned DestW    = 4;
  localparam int unsigned PayloadW = 32;

  typedef logic [RobIdxW-1:0]  rob_idx_t;
  typedef logic [AxLenW-1:0]   ax_len_t;
  typedef logic [DestW-1:0]    dest_t;
  typedef logic [PayloadW-1:0] ax_payload_t;
  typedef logic [PayloadW-1:0] rsp_payload_t;

  typedef struct packed {
    logic     rob_req;
    rob_idx_t rob_idx;
    dest_t    src;
    ax_len_t  len;
  } rob_meta_entry_t;

  // Single conditional subtract; the beat offset is truncated to one bit wider than the index.
  function automatic rob_idx_t rob_idx_add(input rob_idx_t base, input ax_len_t off);
    logic [RobIdxW:0] sum;
    sum = {1'b0, base} + (RobIdxW+1)'(off);
    if (sum >= (RobIdxW+1)'(RobSize)) sum = sum - (RobIdxW+1)'(RobSize);
    return RobIdxW'(sum);
  endfunction

endpackage

// File: rtl/floo_rob_rsp_tagger_fifo.sv
// In-order meta FIFO without fall-through; the head becomes visible the cycle after a push.
module floo_rob_rsp_tagger_fifo #(
  parameter int unsigned Depth = 8,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  dtype            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/floo_rob_rsp_tagger.sv
// Target-side RoB tagger: records request metadata in order and stamps each
// response beat with the initiator's rob_req, per-beat rob_idx and destination.
module floo_rob_rsp_tagger
  import floo_rob_rsp_tagger_pkg::*;
#(
  parameter int unsigned MaxTxns    = 8,
  parameter type         ax_chan_t  = ax_payload_t,
  parameter type         rsp_chan_t = rsp_payload_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      ax_valid_i,
  output logic      ax_ready_o,
  input  ax_chan_t  ax_i,
  input  ax_len_t   ax_len_i,
  input  logic      ax_rob_req_i,
  input  rob_idx_t  ax_rob_idx_i,
  input  dest_t     ax_src_i,
  output logic      ax_valid_o,
  input  logic      ax_ready_i,
  output ax_chan_t  ax_o,
  input  logic      rsp_valid_i,
  output logic      rsp_ready_o,
  input  rsp_chan_t rsp_i,
  input  logic      rsp_last_i,
  output logic      rsp_valid_o,
  input  logic      rsp_ready_i,
  output rsp_chan_t rsp_o,
  output logic      rsp_rob_req_o,
  output rob_idx_t  rsp_rob_idx_o,
  output dest_t     rsp_dest_o,
  output logic      busy_o
);

  rob_meta_entry_t push_entry, head;
  logic            full, empty, push, pop, rsp_hs;
  ax_len_t         beat_q;

  assign ax_valid_o = ax_valid_i & ~full;
  assign ax_ready_o = ax_ready_i & ~full;
  assign ax_o       = ax_i;
  assign push       = ax_valid_i & ax_ready_o;
  assign push_entry = '{rob_req: ax_rob_req_i, rob_idx: ax_rob_idx_i,
                        src: ax_src_i, len: ax_len_i};

  assign rsp_valid_o = rsp_valid_i & ~empty;
  assign rsp_ready_o = rsp_ready_i & ~empty;
  assign rsp_o       = rsp_i;
  assign rsp_hs      = rsp_valid_i & rsp_ready_o;
  assign pop         = rsp_hs & rsp_last_i;
  assign busy_o      = ~empty;

  floo_rob_rsp_tagger_fifo #(
    .Depth (MaxTxns),
    .dtype (rob_meta_entry_t)
  ) i_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Beat counter within the head burst; restarts after the last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else if (rsp_hs) begin
      beat_q <= rsp_last_i ? '0 : beat_q + ax_len_t'(1);
    end
  end

  assign rsp_rob_req_o = empty ? 1'b0 : head.rob_req;
  assign rsp_dest_o    = empty ? '0   : head.src;
  assign rsp_rob_idx_o = empty ? '0   : rob_idx_add(head.rob_idx, beat_q);

  rsp_needs_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_i |-> !empty);

  last_matches_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_i && !empty) |-> (rsp_last_i == (beat_q == head.len)));

endmodule

// File: tb/tb_floo_rob_rsp_tagger.sv
// Directed bench for floo_rob_rsp_tagger: vector table plus hand-written
// sequences for full, back-pressure, mixed concurrency and mid-burst reset.
module tb_floo_rob_rsp_tagger;
  import floo_rob_rsp_tagger_pkg::*;

  logic         clk, rst_n;
  logic         ax_valid_i, ax_ready_o, ax_valid_o, ax_ready_i;
  ax_payload_t  ax_i, ax_o;
  ax_len_t      ax_len_i;
  logic         ax_rob_req_i;
  rob_idx_t     ax_rob_idx_i;
  dest_t        ax_src_i;
  logic         rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
  rsp_payload_t rsp_i, rsp_o;
  logic         rsp_rob_req_o;
  rob_idx_t     rsp_rob_idx_o;
  dest_t        rsp_dest_o;
  logic         busy_o;

  int n_run  = 0;
  int n_fail = 0;

  floo_rob_rsp_tagger #(.MaxTxns(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ax_valid_i    (ax_valid_i),
    .ax_ready_o    (ax_ready_o),
    .ax_i          (ax_i),
    .ax_len_i      (ax_len_i),
    .ax_rob_req_i  (ax_rob_req_i),
    .ax_rob_idx_i  (ax_rob_idx_i),
    .ax_src_i      (ax_src_i),
    .ax_valid_o    (ax_valid_o),
    .ax_ready_i    (ax_ready_i),
    .ax_o          (ax_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_i         (rsp_i),
    .rsp_last_i    (rsp_last_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_o         (rsp_o),
    .rsp_rob_req_o (rsp_rob_req_o),
    .rsp_rob_idx_o (rsp_rob_idx_o),
    .rsp_dest_o    (rsp_dest_o),
    .busy_o        (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic     req;
    rob_idx_t idx;
    dest_t    src;
    ax_len_t  len;
    rob_idx_t exp_idx [4];
  } vec_t;

  typedef struct {
    logic     req;
    rob_idx_t idx;
    dest_t    src;
    ax_len_t  len;
  } meta_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_req(input logic req, input rob_idx_t idx, input dest_t src, input ax_len_t len);
    int n;
    ax_valid_i   = 1'b1;
    ax_ready_i   = 1'b1;
    ax_rob_req_i = req;
    ax_rob_idx_i = idx;
    ax_src_i     = src;
    ax_len_i     = len;
    ax_i         = $urandom;
    #1;
    check("ax_o passthrough", 32'(ax_o), 32'(ax_i));
    n = 0;
    while (!ax_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!ax_ready_o) check("req accept timeout", 32'(ax_ready_o), 32'd1);
    tick();
    ax_valid_i = 1'b0;
  endtask

  task automatic rsp_beat(input logic last, input rob_idx_t exp_idx, input dest_t exp_dest,
                          input logic exp_req);
    rsp_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    rsp_last_i  = last;
    rsp_i       = $urandom;
    #1;
    check("rsp_rob_idx", 32'(rsp_rob_idx_o), 32'(exp_idx));
    check("rsp_dest", 32'(rsp_dest_o), 32'(exp_dest));
    check("rsp_rob_req", 32'(rsp_rob_req_o), 32'(exp_req));
    check("rsp_valid_o", 32'(rsp_valid_o), 32'd1);
    check("rsp_o passthrough", 32'(rsp_o), 32'(rsp_i));
    tick();
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
  endtask

  vec_t  vecs [4];
  meta_t mq [$];

  initial begin
    int beat, cyc, pushed;
    logic rv, push_hs, rsp_hs;
    meta_t m;

    vecs[0] = '{1'b1, 6'd5,  4'd3, 8'd0, '{6'd5,  6'd0,  6'd0, 6'd0}};
    vecs[1] = '{1'b1, 6'd10, 4'd2, 8'd3, '{6'd10, 6'd11, 6'd12, 6'd13}};
    vecs[2] = '{1'b0, 6'd62, 4'd1, 8'd3, '{6'd62, 6'd63, 6'd0, 6'd1}};
    vecs[3] = '{1'b1, 6'd63, 4'd7, 8'd1, '{6'd63, 6'd0,  6'd0, 6'd0}};

    rst_n = 1'b0;
    ax_valid_i = 1'b1; ax_ready_i = 1'b1; ax_i = '0; ax_len_i = '0;
    ax_rob_req_i = 1'b0; ax_rob_idx_i = '0; ax_src_i = '0;
    rsp_valid_i = 1'b1; rsp_ready_i = 1'b1; rsp_i = '0; rsp_last_i = 1'b0;
    #2;
    check("reset rsp_valid_o", 32'(rsp_valid_o), 32'd0);
    check("reset rsp_ready_o", 32'(rsp_ready_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset rsp_rob_idx", 32'(rsp_rob_idx_o), 32'd0);
    check("reset ax_valid_o", 32'(ax_valid_o), 32'd1);
    check("reset ax_ready_o", 32'(ax_ready_o), 32'd1);
    ax_valid_i = 1'b0; rsp_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single transactions from the table
    for (int v = 0; v < 4; v++) begin
      send_req(vecs[v].req, vecs[v].idx, vecs[v].src, vecs[v].len);
      check("busy after push", 32'(busy_o), 32'd1);
      for (int b = 0; b <= int'(vecs[v].len); b++)
        rsp_beat(b == int'(vecs[v].len), vecs[v].exp_idx[b], vecs[v].src, vecs[v].req);
      check("busy after drain", 32'(busy_o), 32'd0);
    end

    // Fill to capacity, then check the 9th is refused even across a pop
    for (int i = 0; i < 8; i++) send_req(1'b1, rob_idx_t'(i * 7), dest_t'(i), 8'd0);
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    ax_rob_req_i = 1'b1; ax_rob_idx_i = 6'd40; ax_src_i = 4'd9; ax_len_i = 8'd0;
    #1;
    check("full ax_ready_o", 32'(ax_ready_o), 32'd0);
    check("full ax_valid_o", 32'(ax_valid_o), 32'd0);
    rsp_valid_i = 1'b1; rsp_ready_i = 1'b1; rsp_last_i = 1'b1;
    #1;
    check("full pop idx", 32'(rsp_rob_idx_o), 32'd0);
    check("no fall-through ax_ready_o", 32'(ax_ready_o), 32'd0);
    tick();
    rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
    #1;
    check("slot freed ax_ready_o", 32'(ax_ready_o), 32'd1);
    tick();
    ax_valid_i = 1'b0;
    for (int i = 1; i < 8; i++) rsp_beat(1'b1, rob_idx_t'(i * 7), dest_t'(i), 1'b1);
    rsp_beat(1'b1, 6'd40, 4'd9, 1'b1);
    check("busy after full drain", 32'(busy_o), 32'd0);

    // Random back-pressure on a 6-beat burst
    send_req(1'b1, 6'd20, 4'd5, 8'd5);
    beat = 0; cyc = 0;
    while (beat <= 5 && cyc < 200) begin
      rsp_valid_i = 1'b1;
      rsp_ready_i = 1'($urandom_range(0, 1));
      rsp_last_i  = (beat == 5);
      #1;
      check("bp rsp_rob_idx", 32'(rsp_rob_idx_o), 32'(20 + beat));
      check("bp rsp_ready_o", 32'(rsp_ready_o), 32'(rsp_ready_i));
      tick();
      if (rsp_ready_i) beat++;
      cyc++;
    end
    rsp_valid_i = 1'b0; rsp_last_i = 1'b0; rsp_ready_i = 1'b1;
    if (beat <= 5) check("bp timeout", 32'(beat), 32'd6);
    check("bp busy after", 32'(busy_o), 32'd0);

    // Mixed concurrent push/pop against a scoreboard
    beat = 0; cyc = 0; pushed = 0;
    while ((pushed < 100 || mq.size() > 0) && cyc < 5000) begin
      ax_valid_i   = (pushed < 100) && ($urandom_range(0, 2) != 0);
      ax_ready_i   = ($urandom_range(0, 3) != 0);
      ax_rob_req_i = 1'($urandom_range(0, 1));
      ax_rob_idx_i = rob_idx_t'($urandom_range(0, 63));
      ax_src_i     = dest_t'($urandom_range(0, 15));
      ax_len_i     = ax_len_t'($urandom_range(0, 3));
      rv           = (mq.size() > 0) && ($urandom_range(0, 3) != 0);
      rsp_valid_i  = rv;
      rsp_ready_i  = ($urandom_range(0, 3) != 0);
      rsp_last_i   = rv && (beat == int'(mq[0].len));
      #1;
      check("conc ax_ready_o", 32'(ax_ready_o), 32'(ax_ready_i && mq.size() < 8));
      check("conc busy_o", 32'(busy_o), 32'(mq.size() > 0));
      if (rv) begin
        check("conc rsp_rob_idx", 32'(rsp_rob_idx_o), 32'((int'(mq[0].idx) + beat) % 64));
        check("conc rsp_dest", 32'(rsp_dest_o), 32'(mq[0].src));
        check("conc rsp_rob_req", 32'(rsp_rob_req_o), 32'(mq[0].req));
      end
      push_hs = ax_valid_i && ax_ready_i && (mq.size() < 8);
      rsp_hs  = rv && rsp_ready_i;
      m = '{ax_rob_req_i, ax_rob_idx_i, ax_src_i, ax_len_i};
      tick();
      if (rsp_hs) begin
        if (rsp_last_i) begin
          void'(mq.pop_front());
          beat = 0;
        end else beat++;
      end
      if (push_hs) begin
        mq.push_back(m);
        pushed++;
      end
      cyc++;
    end
    ax_valid_i = 1'b0; rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
    if (mq.size() > 0 || pushed < 100) check("conc timeout", 32'(pushed), 32'd100);

    // Reset in the middle of a burst
    send_req(1'b1, 6'd30, 4'd2, 8'd3);
    rsp_beat(1'b0, 6'd30, 4'd2, 1'b1);
    rsp_beat(1'b0, 6'd31, 4'd2, 1'b1);
    rst_n = 1'b0;
    ax_valid_i = 1'b1; ax_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_ready_i = 1'b1;
    #1;
    check("midreset busy_o", 32'(busy_o), 32'd0);
    check("midreset rsp_ready_o", 32'(rsp_ready_o), 32'd0);
    check("midreset rsp_valid_o", 32'(rsp_valid_o), 32'd0);
    check("midreset rsp_rob_idx", 32'(rsp_rob_idx_o), 32'd0);
    check("midreset ax_valid_o", 32'(ax_valid_o), 32'd1);
    ax_valid_i = 1'b0; rsp_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_req(1'b1, 6'd7, 4'd4, 8'd0);
    rsp_beat(1'b1, 6'd7, 4'd4, 1'b1);
    check("post-reset busy_o", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
